// File: rtl/intr_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: line count, id width,
// configuration register addresses and FSM state encoding.
package intr_arbiter_pkg;

    localparam int NIRQ  = 8;
    localparam int VEC_W = 3;

    // Configuration register map
    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_PEND = 2'd1;
    localparam logic [1:0] CFG_ISR  = 2'd2;

    // FSM state encoding (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    // One-hot decode of a line index
    function automatic logic [NIRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
        logic [NIRQ-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/intr_arbiter_prio_enc8.sv
// Eight-input fixed-priority encoder: the lowest set index wins and a found
// flag reports whether any input bit was set.
module prio_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       found
);

    // Scan upward and keep the first set bit
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && vec[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: captures rising edges on irq lines into pending bits,
// raises intr toward the CPU, grants the highest-priority eligible line on
// inta and tracks in-service lines until eoi.
// Optional feature: define INTR_NESTED_EN to allow a higher-priority line to
// preempt while a lower-priority line is in service.
module intr_arbiter
    import intr_arbiter_pkg::*;
#(
    parameter int NIRQ  = intr_arbiter_pkg::NIRQ,
    parameter int VEC_W = intr_arbiter_pkg::VEC_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [NIRQ-1:0]  irq,
    output logic             intr,
    input  logic             inta,
    output logic [VEC_W-1:0] irq_id,
    output logic             id_valid,
    output logic             spurious,
    input  logic             eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [NIRQ-1:0]  cfg_wdata,
    output logic [NIRQ-1:0]  cfg_rdata
);

    logic [1:0]       state;
    logic [NIRQ-1:0]  irq_q;
    logic [NIRQ-1:0]  pending;
    logic [NIRQ-1:0]  mask;
    logic [NIRQ-1:0]  isr;

    logic [NIRQ-1:0]  rise;
    logic [NIRQ-1:0]  base_elig;
    logic [NIRQ-1:0]  eligible;
    logic [VEC_W-1:0] win_idx;
    logic             win_found;
    logic [VEC_W-1:0] isr_idx;
    logic             isr_found;
    logic             grant;
    logic             spur_hit;
    logic [NIRQ-1:0]  pending_next;
    logic [NIRQ-1:0]  isr_next;

    prio_enc8 u_enc_elig (
        .vec   (eligible),
        .idx   (win_idx),
        .found (win_found)
    );

    prio_enc8 u_enc_isr (
        .vec   (isr),
        .idx   (isr_idx),
        .found (isr_found)
    );

    // Rising-edge detect against the registered copy of irq
    always_comb begin
        rise = irq & ~irq_q;
    end

    // Eligibility: unmasked pending lines, qualified by the in-service rule
    always_comb begin
        base_elig = pending & ~mask;
        eligible  = '0;
`ifdef INTR_NESTED_EN
        if (isr_found) begin
            // only lines strictly above the top in-service line may preempt
            eligible = base_elig & ((NIRQ'(1) << isr_idx) - NIRQ'(1));
        end else begin
            eligible = base_elig;
        end
`else
        if (!isr_found) begin
            eligible = base_elig;
        end
`endif
    end

    // Acknowledge outcome in ASSERT: real grant or spurious
    always_comb begin
        grant    = (state == ST_ASSERT) && inta && win_found;
        spur_hit = (state == ST_ASSERT) && inta && !win_found;
    end

    // Next pending: cfg clear and grant clear first, new edges win over both
    always_comb begin
        pending_next = pending;
        if (cfg_we && (cfg_addr == CFG_PEND)) begin
            pending_next = pending_next & ~cfg_wdata;
        end
        if (grant) begin
            pending_next = pending_next & ~onehot(win_idx);
        end
        pending_next = pending_next | rise;
    end

    // Next isr: eoi retires the old top bit, then a grant sets the new one
    always_comb begin
        isr_next = isr;
        if (eoi && isr_found) begin
            isr_next = isr_next & ~onehot(isr_idx);
        end
        if (grant) begin
            isr_next = isr_next | onehot(win_idx);
        end
    end

    // Line capture, pending, mask and isr registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
            isr     <= '0;
        end else begin
            irq_q   <= irq;
            pending <= pending_next;
            isr     <= isr_next;
            if (cfg_we && (cfg_addr == CFG_MASK)) begin
                mask <= cfg_wdata;
            end
        end
    end

    // Request FSM: IDLE -> ASSERT on eligibility, ASSERT -> ACK on inta
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (eligible != '0) state <= ST_ASSERT;
                ST_ASSERT: if (inta) state <= ST_ACK;
                ST_ACK:    state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Grant id and one-cycle ACK-phase status flags
    always_ff @(posedge clock) begin
        if (!resetn) begin
            irq_id   <= '0;
            id_valid <= 1'b0;
            spurious <= 1'b0;
        end else begin
            id_valid <= grant;
            spurious <= spur_hit;
            if (grant) begin
                irq_id <= win_idx;
            end
        end
    end

    // intr is simply the registered ASSERT state
    always_comb begin
        intr = (state == ST_ASSERT);
    end

    // Combinational register read-back
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_MASK: cfg_rdata = mask;
            CFG_PEND: cfg_rdata = pending;
            CFG_ISR:  cfg_rdata = isr;
            default:  cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed self-checking bench for intr_arbiter. Expected values are
// hand-derived; nesting expectations follow INTR_NESTED_EN.
module tb_intr_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] irq;
    logic       intr;
    logic       inta;
    logic [2:0] irq_id;
    logic       id_valid;
    logic       spurious;
    logic       eoi;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] rv;

    intr_arbiter #(.NIRQ(8), .VEC_W(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .irq       (irq),
        .intr      (intr),
        .inta      (inta),
        .irq_id    (irq_id),
        .id_valid  (id_valid),
        .spurious  (spurious),
        .eoi       (eoi),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; irq = '0; inta = 1'b0; eoi = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) tick();
        resetn = 1'b1;

        // reset state
        chk("rst_intr", intr, 0);
        chk("rst_idv", id_valid, 0);
        chk("rst_spur", spurious, 0);
        chk("rst_id", irq_id, 0);
        rd(2'd0, rv); chk("rst_mask", rv, 8'hFF);
        rd(2'd1, rv); chk("rst_pend", rv, 8'h00);
        rd(2'd2, rv); chk("rst_isr", rv, 8'h00);
        rd(2'd3, rv); chk("rd_addr3", rv, 8'h00);

        // single request on line 0
        wr(2'd0, 8'hFE);
        irq = 8'h01;
        tick();
        chk("s_intr_n1", intr, 0);
        rd(2'd1, rv); chk("s_pend_n1", rv, 8'h01);
        tick();
        chk("s_intr_n2", intr, 1);
        tick();
        chk("s_intr_hold", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("s_idv", id_valid, 1);
        chk("s_id", irq_id, 0);
        chk("s_intr_ack", intr, 0);
        chk("s_spur", spurious, 0);
        rd(2'd2, rv); chk("s_isr", rv, 8'h01);
        rd(2'd1, rv); chk("s_pend", rv, 8'h00);
        tick();
        chk("s_idv_drop", id_valid, 0);
        chk("s_intr_idle", intr, 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("s_isr_eoi", rv, 8'h00);
        irq = 8'h00;
        inta = 1'b1; tick(); inta = 1'b0;
        chk("idle_inta_idv", id_valid, 0);
        chk("idle_inta_spur", spurious, 0);

        // priority between lines 2 and 5
        wr(2'd0, 8'h00);
        irq = 8'h24;
        tick();
        tick();
        chk("p_intr", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("p_id1", irq_id, 2);
        chk("p_idv1", id_valid, 1);
        rd(2'd1, rv); chk("p_pend1", rv, 8'h20);
        rd(2'd2, rv); chk("p_isr1", rv, 8'h04);
        tick();
        chk("p_intr_busy", intr, 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("p_isr_eoi", rv, 8'h00);
        chk("p_intr_eoi", intr, 0);
        tick();
        chk("p_intr2", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("p_id2", irq_id, 5);
        rd(2'd2, rv); chk("p_isr2", rv, 8'h20);
        rd(2'd1, rv); chk("p_pend2", rv, 8'h00);
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        irq = 8'h00; tick();

        // spurious: line 3 raises intr, then masked before inta
        irq = 8'h08;
        tick();
        tick();
        chk("sp_intr", intr, 1);
        wr(2'd0, 8'hFF);
        chk("sp_intr_hold", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("sp_spur", spurious, 1);
        chk("sp_idv", id_valid, 0);
        chk("sp_id", irq_id, 5);
        rd(2'd2, rv); chk("sp_isr", rv, 8'h00);
        rd(2'd1, rv); chk("sp_pend", rv, 8'h08);
        tick();
        chk("sp_spur_drop", spurious, 0);
        chk("sp_intr_idle", intr, 0);
        wr(2'd1, 8'h08);
        rd(2'd1, rv); chk("sp_pend_clr", rv, 8'h00);
        wr(2'd0, 8'h00);
        irq = 8'h00; tick();

        // nesting: line 4 in service, then line 1 rises
        irq = 8'h10;
        tick();
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        chk("n_id4", irq_id, 4);
        rd(2'd2, rv); chk("n_isr4", rv, 8'h10);
        tick();
        irq = 8'h12;
        tick();
        rd(2'd1, rv); chk("n_pend1", rv, 8'h02);
        tick();
`ifdef INTR_NESTED_EN
        chk("n_intr_nest", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("n_id1", irq_id, 1);
        rd(2'd2, rv); chk("n_isr12", rv, 8'h12);
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("n_isr_eoi1", rv, 8'h10);
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("n_isr_eoi2", rv, 8'h00);
`else
        chk("n_intr_block", intr, 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("n_isr_eoi", rv, 8'h00);
        chk("n_intr_eoi", intr, 0);
        tick();
        chk("n_intr_after", intr, 1);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("n_id1", irq_id, 1);
        rd(2'd2, rv); chk("n_isr02", rv, 8'h02);
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd(2'd2, rv); chk("n_isr_clr", rv, 8'h00);
`endif

        // boundary: pending clear coinciding with a new edge
        wr(2'd0, 8'hFF);
        irq = 8'h00; tick();
        irq = 8'h40; tick();
        rd(2'd1, rv); chk("b_pend_set", rv, 8'h40);
        irq = 8'h00; tick();
        irq = 8'h40;
        wr(2'd1, 8'h40);
        rd(2'd1, rv); chk("b_pend_race", rv, 8'h40);
        wr(2'd1, 8'h40);
        rd(2'd1, rv); chk("b_pend_clr", rv, 8'h00);

        // boundary: reset while in ASSERT
        irq = 8'h00; tick();
        wr(2'd0, 8'h00);
        irq = 8'h80; tick();
        tick();
        chk("r_intr", intr, 1);
        resetn = 1'b0; tick();
        chk("r_intr_drop", intr, 0);
        chk("r_idv", id_valid, 0);
        rd(2'd0, rv); chk("r_mask", rv, 8'hFF);
        rd(2'd1, rv); chk("r_pend", rv, 8'h00);
        resetn = 1'b1;
        irq = 8'h00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
